// File: rtl/imem_boot_pkg.sv
// rtl/imem_boot_pkg.sv - shared types and constants for the instruction-memory boot loader
package imem_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int MAX_WORDS_DEFAULT = 32;
    localparam int BYTES_PER_WORD    = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - 8-to-32 big-endian shift assembler with word-complete pulse
module imem_byte_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    // Only the first three bytes need storage; the fourth is taken straight from the input.
    logic [23:0] r_shift;
    logic [1:0]  r_idx;

    // Shift accepted bytes in MSB first and track the byte position within the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_idx   <= r_idx + 2'd1;
        end
    end

    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_valid && !i_clear && (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a checksummed program frame into instruction memory, then releases the core
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [7:0]    LP_MAX_N = 8'(MAX_WORDS);
    localparam logic [ADDR_W:0] LP_ONE = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_next;
    logic                w_in_ready;
    logic                w_busy;
    logic                w_done;
    logic                w_error;
    logic                w_hdr_ok;
    logic                w_last_word;
    logic                w_begin;
    logic                w_clear_load;
    logic                w_pack_valid;
    logic                w_word_valid;
    logic [31:0]         w_word;

    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_words_loaded;
    logic [7:0]          r_csum;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [31:0]         r_wdata;
    logic                r_cpu_reset;

    assign w_hdr_ok     = (in_data != 8'd0) && (in_data <= LP_MAX_N);
    assign w_last_word  = ((r_words_loaded + LP_ONE) == r_count);
    assign w_begin      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_clear_load = (r_state == ST_IDLE) || w_begin;
    assign w_pack_valid = in_valid && (r_state == ST_DATA);

    imem_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (r_state != ST_DATA),
        .i_valid      (w_pack_valid),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the status outputs that are pure functions of state.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_error    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_HDR;
            end
            ST_HDR: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (in_valid) w_next = w_hdr_ok ? ST_DATA : ST_ERR;
            end
            ST_DATA: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_word_valid && w_last_word) w_next = ST_CHK;
            end
            ST_CHK: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (in_valid) w_next = (in_data == r_csum) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (start) w_next = ST_HDR;
            end
            ST_ERR: begin
                w_error = 1'b1;
                if (start) w_next = ST_HDR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Frame bookkeeping and the registered memory write port; a completed word is written the cycle after its last byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count        <= '0;
            r_words_loaded <= '0;
            r_csum         <= '0;
            r_we           <= 1'b0;
            r_waddr        <= '0;
            r_wdata        <= '0;
            r_cpu_reset    <= 1'b1;
        end else begin
            r_cpu_reset <= (w_next != ST_DONE);
            r_we        <= w_word_valid;
            if (w_clear_load) begin
                r_words_loaded <= '0;
                r_csum         <= '0;
            end else begin
                if (w_word_valid) begin
                    r_waddr        <= r_words_loaded[ADDR_W-1:0];
                    r_wdata        <= w_word;
                    r_words_loaded <= r_words_loaded + LP_ONE;
                end
                if (w_pack_valid) r_csum <= r_csum ^ in_data;
            end
            if ((r_state == ST_HDR) && in_valid && w_hdr_ok) r_count <= in_data[ADDR_W:0];
        end
    end

    assign in_ready     = w_in_ready;
    assign busy         = w_busy;
    assign done         = w_done;
    assign error        = w_error;
    assign imem_we      = r_we;
    assign imem_waddr   = r_waddr;
    assign imem_wdata   = r_wdata;
    assign cpu_reset    = r_cpu_reset;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized self-checking bench with a frame-level reference model
module tb_imem_boot_loader;

    localparam int MW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_boot_loader #(.MAX_WORDS(MW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  byte_q[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    bit          exp_done;
    bit          exp_err;
    bit          hdr_ok;
    bit          tog = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Capture every write strobe away from the clock edge.
    always @(negedge clk) begin
        if (imem_we) begin
            got_addr.push_back(32'(imem_waddr));
            got_data.push_back(imem_wdata);
        end
    end

    // Reference: what a frame should produce, straight from the frame format.
    task automatic model_frame();
        int n;
        logic [7:0] cs;
        n = int'(byte_q[0]);
        exp_data.delete();
        hdr_ok = (n >= 1) && (n <= MW);
        if (!hdr_ok) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        cs = 8'h00;
        for (int w = 0; w < n; w++) begin
            exp_data.push_back({byte_q[1+4*w], byte_q[2+4*w], byte_q[3+4*w], byte_q[4+4*w]});
            for (int k = 1; k <= 4; k++) cs = cs ^ byte_q[4*w+k];
        end
        exp_done = (byte_q[4*n+1] == cs);
        exp_err  = !exp_done;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int mode);
        bit acc = 1'b0;
        int guard = 0;
        while (!acc) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = ~tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? b : 8'($urandom);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            in_valid = 1'b0;
            guard++;
            if (!acc && guard > 50) begin
                chk("xfer_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic send_frame(input int mode);
        int n;
        n = int'(byte_q[0]);
        for (int i = 0; i < byte_q.size(); i++) begin
            push_byte(byte_q[i], mode);
            if (i == 0 && !hdr_ok) begin
                chk("hdr_err", 32'(error), 32'd1);
                chk("hdr_err_ready", 32'(in_ready), 32'd0);
            end
            if (hdr_ok && i >= 1 && i <= 4*n)
                chk("we_timing", 32'(imem_we), 32'((i % 4) == 0));
            if (hdr_ok && i == 4*n + 1) begin
                chk("cpu_reset_after_chk", 32'(cpu_reset), 32'(!exp_done));
                chk("done_after_chk", 32'(done), 32'(exp_done));
            end
        end
    endtask

    task automatic finish_check();
        repeat (3) @(posedge clk);
        #1;
        chk("n_writes", 32'(got_addr.size()), 32'(exp_data.size()));
        for (int i = 0; i < got_addr.size() && i < exp_data.size(); i++) begin
            chk("waddr", got_addr[i], 32'(i));
            chk("wdata", got_data[i], exp_data[i]);
        end
        chk("done", 32'(done), 32'(exp_done));
        chk("error", 32'(error), 32'(exp_err));
        chk("cpu_reset", 32'(cpu_reset), 32'(!exp_done));
        chk("words_loaded", 32'(words_loaded), 32'(exp_data.size()));
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic load_first_frame();
        byte_q = {8'h02, 8'h20, 8'h08, 8'h00, 8'h00, 8'h20, 8'h09, 8'h00, 8'h28, 8'h29};
    endtask

    task automatic build_random();
        int n;
        logic [7:0] cs;
        logic [7:0] b;
        byte_q.delete();
        if ($urandom_range(0, 4) == 0) begin
            b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MW + 1, 255));
            byte_q.push_back(b);
            return;
        end
        n = $urandom_range(1, MW);
        byte_q.push_back(8'(n));
        cs = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            byte_q.push_back(b);
            cs = cs ^ b;
        end
        if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
        byte_q.push_back(cs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2 reset = 1'b1;
        #1;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_waddr", 32'(imem_waddr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed good frame.
        load_first_frame();
        model_frame();
        pulse_start();
        send_frame(0);
        finish_check();

        // Bad checksum, then recovery with the good frame.
        load_first_frame();
        byte_q[9] = 8'h2A;
        model_frame();
        pulse_start();
        send_frame(0);
        finish_check();
        load_first_frame();
        model_frame();
        pulse_start();
        send_frame(0);
        finish_check();

        // Illegal headers.
        byte_q = {8'h00};
        model_frame();
        pulse_start();
        send_frame(0);
        finish_check();
        byte_q = {8'h21};
        model_frame();
        pulse_start();
        send_frame(0);
        finish_check();

        // Valid toggling every cycle.
        load_first_frame();
        model_frame();
        pulse_start();
        send_frame(1);
        finish_check();

        // Full-depth frame of 0..31.
        begin
            logic [7:0] cs;
            cs = 8'h00;
            byte_q = {8'(MW)};
            for (int i = 0; i < MW; i++) begin
                byte_q.push_back(8'h00);
                byte_q.push_back(8'h00);
                byte_q.push_back(8'h00);
                byte_q.push_back(8'(i));
                cs = cs ^ 8'(i);
            end
            byte_q.push_back(cs);
        end
        model_frame();
        pulse_start();
        send_frame(0);
        finish_check();

        // Reset after six payload bytes.
        load_first_frame();
        pulse_start();
        for (int i = 0; i < 7; i++) push_byte(byte_q[i], 0);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_words", 32'(words_loaded), 32'd0);
        chk("midrst_nwrites", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() == 1) begin
            chk("midrst_addr", got_addr[0], 32'd0);
            chk("midrst_data", got_data[0], 32'h2008_0000);
        end
        got_addr.delete();
        got_data.delete();
        @(posedge clk); #1;
        reset = 1'b0;

        // Start in IDLE with a byte offered: the byte must not be taken.
        in_valid = 1'b1;
        in_data  = 8'h02;
        pulse_start();
        in_valid = 1'b0;
        chk("idle_start_busy", 32'(busy), 32'd1);
        model_frame();
        send_frame(0);
        finish_check();

        // Randomized frames.
        for (int it = 0; it < 25; it++) begin
            build_random();
            model_frame();
            pulse_start();
            send_frame($urandom_range(0, 2));
            finish_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream loader for the single-cycle MIPS core. Receives a framed program over a byte-stream valid/ready link and writes it into the 32-word instruction memory through a write port.
- Holds the CPU in reset until a complete frame with a correct checksum has been loaded.
- Frame format: count byte N, then N×4 payload bytes (big-endian, MSB first), then one XOR checksum byte.

Parameters:
- MAX_WORDS, 32, instruction memory depth in words; legal N is 1..MAX_WORDS.
- ADDR_W, 5, word-address width; must satisfy 2^ADDR_W >= MAX_WORDS.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a new load.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  instruction memory write strobe, one-cycle pulse.
- imem_waddr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  instruction word to write.
- cpu_reset  output  1  drives the core reset; high while not DONE.
- busy  output  1  high in HDR, DATA and CHK.
- done  output  1  high in DONE.
- error  output  1  high in ERR.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (asynchronous, active-high): go to IDLE. Reset values: cpu_reset=1, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, error=0, words_loaded=0. Clear the byte counter and the checksum accumulator.
- A byte transfer occurs on any clk edge where in_valid && in_ready. in_data is sampled only on a transfer.
- State machine:
  - IDLE:
    - start -> HDR.
    - Clear words_loaded, checksum accumulator and byte index.
    - in_ready=0.
  - HDR:
    - in_ready=1.
    - On transfer: if N==0 or N>MAX_WORDS -> ERR.
    - Otherwise latch N and go to DATA.
  - DATA:
    - in_ready=1.
    - Each transfer shifts the byte into a 32-bit assembly register, MSB first, and XORs it into the accumulator.
    - On the 4th byte of a word: on the next cycle imem_we=1, imem_waddr=word index, imem_wdata=assembled word, and words_loaded increments in the same cycle.
    - The write register is separate from the assembly register, so in_ready stays 1 and back-to-back bytes are accepted without stall.
    - After the 4th byte of word N-1 -> CHK.
  - CHK:
    - in_ready=1.
    - On transfer: if in_data equals the accumulator -> DONE, otherwise -> ERR.
  - DONE:
    - cpu_reset=0 from the first cycle in DONE, i.e. one cycle after the checksum byte is accepted.
    - in_ready=0.
    - start -> HDR; cpu_reset returns to 1 the cycle after start.
  - ERR:
    - cpu_reset=1, in_ready=0, error=1.
    - start -> HDR, which clears error.
- start is ignored in HDR, DATA and CHK.
- Word index range is 0..N-1 with no wrap. Index N-1 never exceeds MAX_WORDS-1, so address 0 is never overwritten within a load.
- Writes of a frame that later fails its checksum stay in memory. This is harmless because the CPU is held in reset.
- Reset mid-operation: the partially assembled word is discarded with no write, and the FSM returns to IDLE with cpu_reset=1. A write pulse that was already issued stays committed.
- Simultaneous start and a transfer in IDLE: the byte is not accepted (in_ready=0); only the state change occurs.
- All outputs are registered, except in_ready, busy, done and error, which are decoded from state.

Decomposition:
- Shared package imem_boot_pkg holds:
  - state encoding: IDLE, HDR, DATA, CHK, DONE, ERR;
  - the default MAX_WORDS;
  - the byte-per-word constant (4).
- One sub-module, imem_byte_packer: 8-to-32 shift assembler with a 2-bit byte index, a word_valid pulse and a clear input.

Test Plan:
- Start, then bytes 02 20 08 00 00 20 09 00 28 29 -> imem writes addr0=0x20080000, addr1=0x20090028; done=1; cpu_reset=0 one cycle after byte 29; words_loaded=2.
- Same frame with checksum byte 2A -> error=1, cpu_reset stays 1, done=0; start again, then the correct frame -> done=1.
- Header byte 00, and separately header byte 21 (33) -> ERR on the next cycle; in_ready=0; no imem_we pulse.
- Frame from the first test with in_valid toggled 1/0 every cycle -> identical writes and timing relative to transfers; no extra or missing imem_we pulses.
- 32-word frame of values 0x00000000..0x0000001F -> 32 writes at addr 0..31 in order, no second write to addr 0, words_loaded=32, done=1.
- Assert reset after 6 payload bytes -> immediate IDLE, cpu_reset=1, only addr0 was written; restart with the first-test frame -> done=1.
